// File: rtl/bias_pingpong_buffer_if.sv
// ---------------------------------------------------------------------------
// bias_pingpong_buffer_if
//
// Purpose:
//    Groups the loader, swap and read-path signals of the bias ping-pong
//    buffer into one bundle. The buffer itself plugs in through the slave
//    modport. The loader/compute side (or a testbench) uses the master
//    modport.
//
// Signal summary (direction seen from the buffer / slave side):
//    ld_valid    in   loader word valid
//    ld_data     in   bias word to write            [D_WIDTH]
//    ld_last     in   final word of a layer's bias set
//    ld_ready    out  loader can accept a word
//    ld_full     out  shadow bank complete, waiting for swap
//    ld_count    out  words in the last completed load [A_WIDTH+1]
//    swap        in   single-cycle bank exchange request
//    swap_err    out  one-cycle pulse, swap requested while not full
//    active_bank out  bank currently served to readers
//    rd_en       in   read request
//    rd_base     in   first address of the lane group  [A_WIDTH]
//    rd_data     out  N_LANES biases, lane i at [i*D_WIDTH +: D_WIDTH]
//    rd_valid    out  rd_data updated this cycle
// ---------------------------------------------------------------------------
interface bias_pingpong_buffer_if #(
   parameter int D_WIDTH = 16,
   parameter int A_WIDTH = 4,
   parameter int N_LANES = 4
);

   // Loader channel
   logic                       ld_valid;
   logic [D_WIDTH-1:0]         ld_data;
   logic                       ld_last;
   logic                       ld_ready;
   logic                       ld_full;
   logic [A_WIDTH:0]           ld_count;

   // Bank exchange control
   logic                       swap;
   logic                       swap_err;
   logic                       active_bank;

   // Read channel
   logic                       rd_en;
   logic [A_WIDTH-1:0]         rd_base;
   logic [N_LANES*D_WIDTH-1:0] rd_data;
   logic                       rd_valid;

   // The buffer sits on this side: it consumes requests and drives status.
   modport slave (
      input  ld_valid,
      input  ld_data,
      input  ld_last,
      output ld_ready,
      output ld_full,
      output ld_count,
      input  swap,
      output swap_err,
      output active_bank,
      input  rd_en,
      input  rd_base,
      output rd_data,
      output rd_valid
   );

   // The loader / MAC-array side drives requests and observes status.
   modport master (
      output ld_valid,
      output ld_data,
      output ld_last,
      input  ld_ready,
      input  ld_full,
      input  ld_count,
      output swap,
      input  swap_err,
      input  active_bank,
      output rd_en,
      output rd_base,
      input  rd_data,
      input  rd_valid
   );

endinterface

// File: rtl/bias_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// bias_pingpong_buffer
//
// Purpose:
//    Double-banked bias store for the DNN datapath. A streaming loader fills
//    the shadow bank with the next layer's biases while the MAC array reads
//    N_LANES consecutive biases per access from the active bank. A swap
//    command exchanges the banks without stalling the compute side.
//
// Ports:
//    clk   in   rising-edge clock
//    rst   in   asynchronous active-high reset
//    bus   slave modport of bias_pingpong_buffer_if (loader, swap and read
//          channels; see the interface file for the signal list)
//
// Parameters:
//    D_WIDTH  bits per bias word
//    A_WIDTH  address bits per bank, DEPTH = 2**A_WIDTH
//    N_LANES  biases returned per read (1..DEPTH)
//
// Bank contents are unknown until a load and swap has happened.
// ---------------------------------------------------------------------------
module bias_pingpong_buffer #(
   parameter int D_WIDTH = 16,
   parameter int A_WIDTH = 4,
   parameter int N_LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   bias_pingpong_buffer_if.slave  bus
);

   localparam int DEPTH = 2 ** A_WIDTH;

   // The loader either accepts words into the shadow bank (LOAD) or holds a
   // completed shadow bank until the compute side asks for a swap (FULL).
   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } loadState_t;

   loadState_t                 stateQ, stateD;
   logic [A_WIDTH-1:0]         wrPtrQ, wrPtrD;
   logic [A_WIDTH:0]           ldCountQ, ldCountD;
   logic                       activeBankQ, activeBankD;
   logic                       swapErrQ, swapErrD;
   logic [N_LANES*D_WIDTH-1:0] rdDataQ, rdDataD;
   logic                       rdValidQ, rdValidD;

   logic                       ldAccept;
   logic [A_WIDTH-1:0]         laneAddr;

   // Both banks live in one array; the top address bit selects the bank, so
   // {bank, offset} indexes a word directly.
   logic [D_WIDTH-1:0]         mem [2*DEPTH];

   // Loader FSM and swap handling. Words are only taken while in LOAD; the
   // transition to FULL happens either on an explicit last marker or when
   // the final bank location has been written. A swap only has an effect
   // when the shadow bank is complete; otherwise it is flagged as an error
   // and everything else is left alone so the load carries on undisturbed.
   always_comb begin
      stateD      = stateQ;
      wrPtrD      = wrPtrQ;
      ldCountD    = ldCountQ;
      activeBankD = activeBankQ;
      swapErrD    = 1'b0;
      ldAccept    = 1'b0;

      case (stateQ)
         LOAD: begin
            if (bus.ld_valid) begin
               ldAccept = 1'b1;
               wrPtrD   = wrPtrQ + A_WIDTH'(1);
               if (bus.ld_last || (wrPtrQ == A_WIDTH'(DEPTH - 1))) begin
                  stateD   = FULL;
                  ldCountD = {1'b0, wrPtrQ} + (A_WIDTH + 1)'(1);
               end
            end
            if (bus.swap) begin
               swapErrD = 1'b1;
            end
         end

         FULL: begin
            if (bus.swap) begin
               activeBankD = ~activeBankQ;
               wrPtrD      = '0;
               stateD      = LOAD;
            end
         end

         default: begin
            stateD = LOAD;
         end
      endcase
   end

   // Read path. Each lane wraps independently modulo DEPTH, which falls out
   // of the A_WIDTH-bit address addition. The bank select is the registered
   // active bank, so a read that coincides with a swap still sees the bank
   // that was active before the edge. When no read is requested the data
   // register simply keeps its previous contents.
   always_comb begin
      rdDataD  = rdDataQ;
      rdValidD = bus.rd_en;
      laneAddr = '0;

      if (bus.rd_en) begin
         for (int i = 0; i < N_LANES; i++) begin
            laneAddr = bus.rd_base + A_WIDTH'(i);
            rdDataD[i*D_WIDTH +: D_WIDTH] = mem[{activeBankQ, laneAddr}];
         end
      end
   end

   // Control and read-data registers. Reset puts the loader back at the
   // start of the shadow bank with bank 0 active and clears all visible
   // outputs; it deliberately leaves the bias memory alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ      <= LOAD;
         wrPtrQ      <= '0;
         ldCountQ    <= '0;
         activeBankQ <= 1'b0;
         swapErrQ    <= 1'b0;
         rdDataQ     <= '0;
         rdValidQ    <= 1'b0;
      end else begin
         stateQ      <= stateD;
         wrPtrQ      <= wrPtrD;
         ldCountQ    <= ldCountD;
         activeBankQ <= activeBankD;
         swapErrQ    <= swapErrD;
         rdDataQ     <= rdDataD;
         rdValidQ    <= rdValidD;
      end
   end

   // Bias memory write port. The loader always targets the bank that is not
   // being served, so a write can never alias with a read in the same cycle.
   // Writes are suppressed while reset is held so a loader that keeps
   // ld_valid asserted through reset does not disturb the shadow bank.
   always_ff @(posedge clk) begin
      if (ldAccept && !rst) begin
         mem[{~activeBankQ, wrPtrQ}] <= bus.ld_data;
      end
   end

   // Status outputs. Ready and full are decoded straight from the loader
   // state so they follow an asynchronous reset immediately.
   assign bus.ld_ready    = (stateQ == LOAD);
   assign bus.ld_full     = (stateQ == FULL);
   assign bus.ld_count    = ldCountQ;
   assign bus.swap_err    = swapErrQ;
   assign bus.active_bank = activeBankQ;
   assign bus.rd_data     = rdDataQ;
   assign bus.rd_valid    = rdValidQ;

endmodule

// File: tb/tb_bias_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// tb_bias_pingpong_buffer
//
// Purpose:
//    Self-checking bench for bias_pingpong_buffer. Directed stimulus walks
//    through full loads, short loads with ld_last, lane wrap-around, swap
//    errors, reads that coincide with a swap and an asynchronous reset in
//    the middle of a load. Every read pushes its hand-computed lane image
//    into a queue; a separate monitor pops and compares whenever the DUT
//    raises rd_valid. Status outputs are compared directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_bias_pingpong_buffer;

   localparam int D_WIDTH = 16;
   localparam int A_WIDTH = 4;
   localparam int N_LANES = 4;

   logic clk;
   logic rst;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [63:0] expQ [$];

   bias_pingpong_buffer_if #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH),
      .N_LANES (N_LANES)
   ) busIf ();

   bias_pingpong_buffer #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH),
      .N_LANES (N_LANES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls the stimulus.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one cycle worth of inputs, queues the expected read result if a
   // read is requested, then waits for the edge and steps 1 unit past it.
   task automatic applyStimulus(input logic ldv, input logic [15:0] data,
                                input logic last, input logic sw,
                                input logic re, input logic [3:0] base,
                                input logic [63:0] expData);
      busIf.ld_valid = ldv;
      busIf.ld_data  = data;
      busIf.ld_last  = last;
      busIf.swap     = sw;
      busIf.rd_en    = re;
      busIf.rd_base  = base;
      if (re) expQ.push_back(expData);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the active
   // edge, and matches every valid read against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (busIf.rd_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("rd_valid_unexpected", 64'(busIf.rd_valid), 64'd0);
            end else begin
               checkOutput("rd_data", busIf.rd_data, expQ.pop_front());
            end
         end
      end
   end

   initial begin
      rst            = 1'b1;
      busIf.ld_valid = 1'b0;
      busIf.ld_data  = '0;
      busIf.ld_last  = 1'b0;
      busIf.swap     = 1'b0;
      busIf.rd_en    = 1'b0;
      busIf.rd_base  = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      checkOutput("rst_ld_ready",    64'(busIf.ld_ready),    64'd1);
      checkOutput("rst_ld_full",     64'(busIf.ld_full),     64'd0);
      checkOutput("rst_ld_count",    64'(busIf.ld_count),    64'd0);
      checkOutput("rst_swap_err",    64'(busIf.swap_err),    64'd0);
      checkOutput("rst_active_bank", 64'(busIf.active_bank), 64'd0);
      checkOutput("rst_rd_valid",    64'(busIf.rd_valid),    64'd0);
      checkOutput("rst_rd_data",     busIf.rd_data,          64'd0);
      rst = 1'b0;
      idle();

      // Test 1: full 16-word load without ld_last, swap, read base 0
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
         if (i == 15) checkOutput("t1_not_full_at_15", 64'(busIf.ld_full), 64'd0);
      end
      checkOutput("t1_ld_full",  64'(busIf.ld_full),  64'd1);
      checkOutput("t1_ld_ready", 64'(busIf.ld_ready), 64'd0);
      checkOutput("t1_ld_count", 64'(busIf.ld_count), 64'd16);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0);
      checkOutput("t1_active_bank", 64'(busIf.active_bank), 64'd1);
      checkOutput("t1_ready_after_swap", 64'(busIf.ld_ready), 64'd1);
      checkOutput("t1_swap_err", 64'(busIf.swap_err), 64'd0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 64'h0004_0003_0002_0001);

      // Test 3: lane wrap-around from base 14
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd14, 64'h0002_0001_0010_000F);
      idle();
      checkOutput("hold_rd_valid", 64'(busIf.rd_valid), 64'd0);
      checkOutput("hold_rd_data",  busIf.rd_data, 64'h0002_0001_0010_000F);

      // Test 2: short load with ld_last, extra words ignored, swap, read
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'h00A0 + 16'(i), (i == 4), 1'b0, 1'b0, 4'd0, 64'h0);
      end
      checkOutput("t2_ld_full",  64'(busIf.ld_full),  64'd1);
      checkOutput("t2_ld_ready", 64'(busIf.ld_ready), 64'd0);
      checkOutput("t2_ld_count", 64'(busIf.ld_count), 64'd5);
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
      applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0);
      checkOutput("t2_still_full",  64'(busIf.ld_full),  64'd1);
      checkOutput("t2_count_stays", 64'(busIf.ld_count), 64'd5);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0);
      checkOutput("t2_active_bank", 64'(busIf.active_bank), 64'd0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 64'h00A3_00A2_00A1_00A0);

      // Test 4: swap during LOAD after 3 words
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
      end
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0);
      checkOutput("t4_swap_err_high", 64'(busIf.swap_err),    64'd1);
      checkOutput("t4_bank_kept",     64'(busIf.active_bank), 64'd0);
      checkOutput("t4_still_loading", 64'(busIf.ld_ready),    64'd1);
      idle();
      checkOutput("t4_swap_err_low",  64'(busIf.swap_err),    64'd0);
      applyStimulus(1'b1, 16'h0B03, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0);
      checkOutput("t4_ld_count", 64'(busIf.ld_count), 64'd4);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0);
      checkOutput("t4_active_bank", 64'(busIf.active_bank), 64'd1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 64'h0B03_0B02_0B01_0B00);

      // Test 5: continuous reads while loading the shadow bank, then a swap
      // on the same edge as a read
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'h0C00 + 16'(i), (i == 3), 1'b0, 1'b1, 4'd0,
                       64'h0B03_0B02_0B01_0B00);
         checkOutput("t5_rd_valid_loading", 64'(busIf.rd_valid), 64'd1);
      end
      checkOutput("t5_ld_full", 64'(busIf.ld_full), 64'd1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 4'd0, 64'h0B03_0B02_0B01_0B00);
      checkOutput("t5_rd_valid_swap", 64'(busIf.rd_valid),    64'd1);
      checkOutput("t5_active_bank",   64'(busIf.active_bank), 64'd0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 64'h0C03_0C02_0C01_0C00);
      checkOutput("t5_rd_valid_after", 64'(busIf.rd_valid), 64'd1);
      idle();

      // Test 6: asynchronous reset between edges in the middle of a load
      applyStimulus(1'b1, 16'h0D00, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
      applyStimulus(1'b1, 16'h0D01, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
      busIf.ld_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_ld_ready",    64'(busIf.ld_ready),    64'd1);
      checkOutput("t6_ld_full",     64'(busIf.ld_full),     64'd0);
      checkOutput("t6_ld_count",    64'(busIf.ld_count),    64'd0);
      checkOutput("t6_active_bank", 64'(busIf.active_bank), 64'd0);
      checkOutput("t6_rd_data",     busIf.rd_data,          64'd0);
      checkOutput("t6_rd_valid",    64'(busIf.rd_valid),    64'd0);
      #2;
      rst = 1'b0;
      idle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'h0E00 + 16'(i), (i == 2), 1'b0, 1'b0, 4'd0, 64'h0);
      end
      checkOutput("t6_reload_count", 64'(busIf.ld_count), 64'd3);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0);
      checkOutput("t6_active_bank_swap", 64'(busIf.active_bank), 64'd1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0,  64'h0B03_0E02_0E01_0E00);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd14, 64'h0E01_0E00_0010_000F);
      idle();
      idle();

      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/bias_pingpong_buffer.md
Name: bias_pingpong_buffer

Overview:
Double-banked bias store for the DNN datapath.
- A streaming loader fills the shadow bank with the next layer's biases while the MAC array reads the active bank.
- The reader fetches N_LANES consecutive biases per access.
- A swap command exchanges the two banks without stalling the compute side.

Parameters:
D_WIDTH, 16, bits per bias word
A_WIDTH, 4, address bits per bank; depth DEPTH = 2**A_WIDTH
N_LANES, 4, biases returned per read (1..DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
ld_valid  input  1  loader word valid
ld_data  input  D_WIDTH  bias word to write
ld_last  input  1  marks final word of a layer's bias set
ld_ready  output  1  loader can accept a word
ld_full  output  1  shadow bank complete, waiting for swap
ld_count  output  A_WIDTH+1  number of words in the last completed load
swap  input  1  single-cycle request to exchange banks
swap_err  output  1  one-cycle pulse: swap requested while not ld_full
active_bank  output  1  bank currently served to readers
rd_en  input  1  read request
rd_base  input  A_WIDTH  first address of the lane group
rd_data  output  N_LANES*D_WIDTH  lane i in bits [i*D_WIDTH +: D_WIDTH]
rd_valid  output  1  rd_data updated this cycle

Behaviour:
Reset (async, all outputs and state):
- rd_data=0, rd_valid=0, ld_ready=1, ld_full=0, ld_count=0, swap_err=0, active_bank=0.
- Loader state LOAD, wr_ptr=0.
- Memory contents are not cleared.

Storage:
- Two banks of DEPTH x D_WIDTH.
- Loader writes only to bank ~active_bank; reader reads only active_bank.

Loader FSM has two states, LOAD and FULL.
- LOAD: ld_ready=1. A word is accepted on a clock edge with ld_valid && ld_ready; it is written to shadow[wr_ptr] and wr_ptr increments.
- Go to FULL if the accepted word has ld_last=1 or wr_ptr==DEPTH-1. On entry: ld_count = wr_ptr+1, ld_full=1, ld_ready=0.
- FULL: ld_ready=0; ld_valid is ignored.
- swap while FULL: active_bank toggles at that edge, wr_ptr=0, state becomes LOAD, ld_full=0, ld_ready=1 from the next cycle.
- swap while LOAD: ignored; swap_err=1 for exactly one cycle; active_bank unchanged.
- Entries past ld_count in the new active bank keep stale contents. The consumer must not read them.

Read path:
- Latency 1. On an edge with rd_en=1, rd_data lane i = active[(rd_base+i) mod DEPTH] and rd_valid=1 for that cycle.
- Address wrap-around is modulo DEPTH per lane.
- rd_en=0: rd_valid=0, rd_data holds its last value.
- Back-to-back reads are allowed every cycle.

Simultaneous events:
- swap and rd_en on the same edge: the read uses the bank that was active before the edge.
- A loader write and a read never alias, because they target different banks.

Reset mid-load: wr_ptr returns to 0; partially written shadow words remain but are overwritten by the next load.

Optional Feature:
BIAS_PRELOAD_EN
- Defined: both banks are initialised at time zero from "bias.txt" (binary, one word per line; bank 0 is words 0..DEPTH-1, bank 1 is words DEPTH..2*DEPTH-1). Reads after reset return the file contents without any load.
- Undefined: no initialisation; bank contents are X until loaded and swapped. Behaviour is otherwise identical.

Test Plan:
1. Load 0x0001..0x0010 (16 words, no ld_last), swap, read rd_base=0 -> ld_full after word 16, ld_count=16, active_bank=1, rd_data lanes = 0x0001,0x0002,0x0003,0x0004 one cycle after rd_en.
2. Load 5 words 0x00A0..0x00A4 with ld_last on the 5th -> ld_full=1, ld_ready=0, ld_count=5; extra ld_valid words are not written; swap; read base 0 -> lanes 0x00A0..0x00A3.
3. Wrap: after test 1, read rd_base=14 -> lanes 0x000F,0x0010,0x0001,0x0002.
4. swap pulse during LOAD (3 words in) -> swap_err high exactly one cycle, active_bank unchanged, loading continues at wr_ptr=3.
5. Continuous rd_en from bank A while loading bank B, then swap with rd_en on the same edge -> that read returns bank A data; the next read returns bank B data; no rd_valid gaps.
6. Assert rst asynchronously mid-load (between edges) -> outputs go to reset values immediately; reload from wr_ptr=0 succeeds.
